// File: rtl/iiitb_sd_pkg.sv
// Shared helpers for the serial sequence detector: the state width, the IDLE
// encoding and the elaboration-time next-state function.
package iiitb_sd_pkg;

   localparam int SD_IDLE = 0;

   function automatic int sd_state_w(input int pattern_w);
      return $clog2(pattern_w + 1);
   endfunction

   // Bit i of the pattern in arrival order (i = 0 is the first bit received).
   function automatic logic sd_pat_bit(input logic [31:0] pattern, input int width, input int i);
      return 1'(pattern >> (width - 1 - i));
   endfunction

   // Longest prefix of the pattern that is a suffix of (matched prefix k, din).
   function automatic int sd_next_state(input logic [31:0] pattern, input int width,
                                        input int overlap, input int k, input logic din);
      int  kk;
      int  len;
      int  best;
      int  p;
      bit  ok;
      logic sb;
      kk   = (k == width && overlap == 0) ? 0 : k;
      len  = kk + 1;
      best = 0;
      for (int j = 1; j <= width; j++) begin
         if (j <= len) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
               p  = len - j + i;
               sb = (p == kk) ? din : sd_pat_bit(pattern, width, p);
               if (sb != sd_pat_bit(pattern, width, i)) ok = 1'b0;
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/iiitb_sd_moore.sv
// Moore serial sequence detector: the state is the matched-prefix length and y
// decodes the full-match state only, so din never reaches y combinationally.
module iiitb_sd_moore
   import iiitb_sd_pkg::*;
#(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
   parameter int                   OVERLAP   = 1
) (
   input  logic din,
   input  logic reset,
   input  logic clk,
   output logic y
);

   localparam int             SW       = sd_state_w(PATTERN_W);
   localparam logic [SW-1:0]  IDLE_ST  = SW'(SD_IDLE);
   localparam logic [SW-1:0]  MATCH_ST = SW'(PATTERN_W);

   if (PATTERN_W < 2) begin : g_bad_width
      $error("iiitb_sd_moore: PATTERN_W must be at least 2");
   end
   if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_overlap
      $error("iiitb_sd_moore: OVERLAP must be 0 or 1");
   end

   logic [SW-1:0] nxt_tbl [PATTERN_W+1][2];

   for (genvar gk = 0; gk <= PATTERN_W; gk++) begin : g_state
      for (genvar gd = 0; gd < 2; gd++) begin : g_din
         assign nxt_tbl[gk][gd] =
            SW'(sd_next_state(32'(PATTERN), PATTERN_W, OVERLAP, gk, 1'(gd)));
      end
   end

   // NOTE: the declaration initialiser gives a defined power-on state (y = 0)
   // even if reset is never asserted; reset still forces IDLE at runtime.
   logic [SW-1:0] state_q = IDLE_ST;
   logic [SW-1:0] state_d;

   always_comb begin
      state_d = nxt_tbl[state_q][din];
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE_ST;
      else       state_q <= state_d;
   end

   assign y = (state_q == MATCH_ST);

endmodule

// File: tb/tb_iiitb_sd_moore.sv
// Directed bench for iiitb_sd_moore: default, non-overlapping and 5-bit
// pattern instances, with hand-computed per-bit detect expectations.
module tb_iiitb_sd_moore;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic din   = 1'b0;
   logic y_def, y_nov, y_alt;

   int total = 0;
   int bad   = 0;

   iiitb_sd_moore dut_def (.din(din), .reset(reset), .clk(clk), .y(y_def));

   iiitb_sd_moore #(.OVERLAP(0)) dut_nov (.din(din), .reset(reset), .clk(clk), .y(y_nov));

   iiitb_sd_moore #(.PATTERN_W(5), .PATTERN(5'b11011), .OVERLAP(1))
      dut_alt (.din(din), .reset(reset), .clk(clk), .y(y_alt));

   always #5 clk = ~clk;

   // Drive off-edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic b, input logic r);
      @(negedge clk);
      din   = b;
      reset = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1);
      reset = 1'b0;
   endtask

   task automatic test_power_up();
      logic [9:0] seq;
      logic [9:0] exp;
      seq = 10'b0111010101;
      exp = 10'b0000001010;
      #1;
      total++;
      if (y_def !== 1'b0) begin
         bad++;
         $display("FAIL power_up_t0 y=%b expected=0", y_def);
      end
      for (int i = 9; i >= 0; i--) begin
         step(seq[i], 1'b0);
         total++;
         if (y_def !== exp[i]) begin
            bad++;
            $display("FAIL power_up sample%0d y=%b expected=%b", 10 - i, y_def, exp[i]);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (y_def !== 1'b0) begin
         bad++;
         $display("FAIL reset_value y=%b expected=0", y_def);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      total++;
      if (y_def !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_s3 y=%b expected=0", y_def);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      total++;
      if (y_def !== 1'b1) begin
         bad++;
         $display("FAIL reset_then_match y=%b expected=1", y_def);
      end
   endtask

   task automatic test_near_miss();
      logic [3:0] pats [3];
      logic [3:0] p;
      pats[0] = 4'b1001;
      pats[1] = 4'b1100;
      pats[2] = 4'b0000;
      for (int n = 0; n < 3; n++) begin
         do_reset();
         p = pats[n];
         for (int i = 3; i >= 0; i--) begin
            step(p[i], 1'b0);
            total++;
            if (y_def !== 1'b0) begin
               bad++;
               $display("FAIL near_miss pat%b bit%0d y=%b expected=0", p, 4 - i, y_def);
            end
         end
      end
   endtask

   task automatic test_non_overlap();
      logic [5:0] seq_a, exp_a;
      logic [7:0] seq_b, exp_b;
      seq_a = 6'b101010;
      exp_a = 6'b000100;
      seq_b = 8'b10101010;
      exp_b = 8'b00010001;
      do_reset();
      for (int i = 5; i >= 0; i--) begin
         step(seq_a[i], 1'b0);
         total++;
         if (y_nov !== exp_a[i]) begin
            bad++;
            $display("FAIL non_overlap_a bit%0d y=%b expected=%b", 6 - i, y_nov, exp_a[i]);
         end
      end
      do_reset();
      for (int i = 7; i >= 0; i--) begin
         step(seq_b[i], 1'b0);
         total++;
         if (y_nov !== exp_b[i]) begin
            bad++;
            $display("FAIL non_overlap_b bit%0d y=%b expected=%b", 8 - i, y_nov, exp_b[i]);
         end
      end
   endtask

   task automatic test_alt_pattern();
      logic [7:0] seq, exp;
      seq = 8'b11011011;
      exp = 8'b00001001;
      do_reset();
      for (int i = 7; i >= 0; i--) begin
         step(seq[i], 1'b0);
         total++;
         if (y_alt !== exp[i]) begin
            bad++;
            $display("FAIL alt_pattern bit%0d y=%b expected=%b", 8 - i, y_alt, exp[i]);
         end
      end
   endtask

   task automatic test_reset_final_bit();
      logic [3:0] seq;
      do_reset();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      total++;
      if (y_def !== 1'b0) begin
         bad++;
         $display("FAIL reset_final_bit y=%b expected=0", y_def);
      end
      seq = 4'b1010;
      for (int i = 3; i >= 0; i--) begin
         step(seq[i], 1'b0);
         total++;
         if (y_def !== (i == 0)) begin
            bad++;
            $display("FAIL reset_final_bit_after bit%0d y=%b expected=%b", 4 - i, y_def, (i == 0));
         end
      end
   endtask

   initial begin
      test_power_up();
      test_reset();
      test_near_miss();
      test_non_overlap();
      test_alt_pattern();
      test_reset_final_bit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
